// File: rtl/spike_event_decoder.sv
// spike_event_decoder: decodes the per-slot spike/spkid stream of the
// time-multiplexed 128-neuron core into an event FIFO of fired neuron IDs,
// a per-sweep population snapshot with spike count, and sticky error flags.
// Optional build macro SWEEP_STAMP_EN adds a 16-bit sweep_num output stamped
// on every snapshot load.
//
// Timing: sampling edge E0 registers the slot; E1 runs the sequence check and
// updates the working set; E2 writes the FIFO and, for slot 127, loads the
// snapshot.
module spike_event_decoder #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_bar,
  input  logic                  spkid_valid,
  input  logic [15:0]           spkid,
  input  logic                  spike,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [6:0]            ev_id,
  output logic                  sweep_valid,
  input  logic                  sweep_ready,
  output logic [127:0]          population,
  output logic [7:0]            spike_count,
  output logic                  sweep_partial,
  output logic                  fmt_err,
  output logic                  seq_err,
  output logic                  overrun,
  output logic [DROP_CNT_W-1:0] drop_cnt
`ifdef SWEEP_STAMP_EN
  ,
  output logic [15:0]           sweep_num
`endif
);

  localparam logic [FIFO_AW:0] FifoFull = (FIFO_AW+1)'(FIFO_DEPTH);

  logic                  s1_valid_q, s1_valid_d;
  logic [6:0]            s1_idx_q, s1_idx_d;
  logic                  s1_f_q, s1_f_d;
  logic [6:0]            exp_idx_q, exp_idx_d;
  logic [127:0]          wpop_q, wpop_d;
  logic [7:0]            wcnt_q, wcnt_d;
  logic                  wpart_q, wpart_d;
  logic                  load_q, load_d;
  logic                  push_q, push_d;
  logic [6:0]            push_id_q, push_id_d;
  logic [127:0]          snap_pop_q, snap_pop_d;
  logic [7:0]            snap_cnt_q, snap_cnt_d;
  logic                  snap_part_q, snap_part_d;
  logic                  sweep_valid_q, sweep_valid_d;
  logic                  fmt_err_q, fmt_err_d;
  logic                  seq_err_q, seq_err_d;
  logic                  overrun_q, overrun_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [6:0]            mem_q [FIFO_DEPTH];
  logic [6:0]            mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_AW:0]      cnt_q, cnt_d;
`ifdef SWEEP_STAMP_EN
  logic [15:0]           sweep_ctr_q, sweep_ctr_d;
  logic [15:0]           sweep_num_q, sweep_num_d;
`endif

  logic         slot_bad;
  logic [127:0] base_pop;
  logic [7:0]   base_cnt;
  logic         base_part;
  logic         do_pop, do_push, fifo_full;

  // Next-state for the whole pipeline: sampling, sequencing, snapshot and FIFO.
  always_comb begin
    // Stage 1: format check on the raw slot word.
    slot_bad   = spkid[15] | (spkid[6:0] != 7'd0) | (spike != spkid[7]);
    s1_valid_d = spkid_valid & ~slot_bad;
    s1_idx_d   = spkid[14:8];
    s1_f_d     = spkid[7];
    fmt_err_d  = fmt_err_q | (spkid_valid & slot_bad);

    // Stage 2: a snapshot load on this edge hands off the working set, so the
    // incoming slot builds on a cleared one.
    base_pop  = load_q ? '0 : wpop_q;
    base_cnt  = load_q ? 8'd0 : wcnt_q;
    base_part = load_q ? 1'b0 : wpart_q;
    wpop_d    = base_pop;
    wcnt_d    = base_cnt;
    wpart_d   = base_part;
    exp_idx_d = exp_idx_q;
    seq_err_d = seq_err_q;
    load_d    = 1'b0;
    push_d    = 1'b0;
    push_id_d = s1_idx_q;
    if (s1_valid_q) begin
      if (s1_idx_q != exp_idx_q) begin
        seq_err_d = 1'b1;
        wpop_d    = '0;
        wcnt_d    = 8'd0;
        wpart_d   = 1'b1;
      end
      wpop_d[s1_idx_q] = s1_f_q;
      wcnt_d           = wcnt_d + {7'd0, s1_f_q};
      exp_idx_d        = s1_idx_q + 7'd1;
      load_d           = (s1_idx_q == 7'd127);
      push_d           = s1_f_q;
    end

    // Snapshot register and handshake.
    snap_pop_d    = snap_pop_q;
    snap_cnt_d    = snap_cnt_q;
    snap_part_d   = snap_part_q;
    sweep_valid_d = sweep_valid_q;
    overrun_d     = overrun_q;
`ifdef SWEEP_STAMP_EN
    sweep_ctr_d   = sweep_ctr_q;
    sweep_num_d   = sweep_num_q;
`endif
    if (load_q) begin
      snap_pop_d    = wpop_q;
      snap_cnt_d    = wcnt_q;
      snap_part_d   = wpart_q;
      sweep_valid_d = 1'b1;
      if (sweep_valid_q && !sweep_ready) overrun_d = 1'b1;
`ifdef SWEEP_STAMP_EN
      sweep_ctr_d   = sweep_ctr_q + 16'd1;
      sweep_num_d   = sweep_ctr_q + 16'd1;
`endif
    end else if (sweep_valid_q && sweep_ready) begin
      sweep_valid_d = 1'b0;
    end

    // Event FIFO: a pop frees the slot a same-edge push needs when full.
    fifo_full  = (cnt_q == FifoFull);
    do_pop     = (cnt_q != '0) & ev_ready;
    do_push    = push_q & (~fifo_full | do_pop);
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = push_id_q;
      wptr_d        = wptr_q + 1'b1;
    end
    if (do_pop) rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    if (push_q && !do_push && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // State registers; asynchronous clear of every pipeline, snapshot and FIFO flop.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      s1_valid_q    <= 1'b0;
      s1_idx_q      <= 7'd0;
      s1_f_q        <= 1'b0;
      exp_idx_q     <= 7'd0;
      wpop_q        <= '0;
      wcnt_q        <= 8'd0;
      wpart_q       <= 1'b0;
      load_q        <= 1'b0;
      push_q        <= 1'b0;
      push_id_q     <= 7'd0;
      snap_pop_q    <= '0;
      snap_cnt_q    <= 8'd0;
      snap_part_q   <= 1'b0;
      sweep_valid_q <= 1'b0;
      fmt_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      overrun_q     <= 1'b0;
      drop_cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 7'd0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      cnt_q         <= '0;
`ifdef SWEEP_STAMP_EN
      sweep_ctr_q   <= 16'd0;
      sweep_num_q   <= 16'd0;
`endif
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_idx_q      <= s1_idx_d;
      s1_f_q        <= s1_f_d;
      exp_idx_q     <= exp_idx_d;
      wpop_q        <= wpop_d;
      wcnt_q        <= wcnt_d;
      wpart_q       <= wpart_d;
      load_q        <= load_d;
      push_q        <= push_d;
      push_id_q     <= push_id_d;
      snap_pop_q    <= snap_pop_d;
      snap_cnt_q    <= snap_cnt_d;
      snap_part_q   <= snap_part_d;
      sweep_valid_q <= sweep_valid_d;
      fmt_err_q     <= fmt_err_d;
      seq_err_q     <= seq_err_d;
      overrun_q     <= overrun_d;
      drop_cnt_q    <= drop_cnt_d;
      mem_q         <= mem_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      cnt_q         <= cnt_d;
`ifdef SWEEP_STAMP_EN
      sweep_ctr_q   <= sweep_ctr_d;
      sweep_num_q   <= sweep_num_d;
`endif
    end
  end

  assign ev_valid      = (cnt_q != '0);
  assign ev_id         = mem_q[rptr_q];
  assign sweep_valid   = sweep_valid_q;
  assign population    = snap_pop_q;
  assign spike_count   = snap_cnt_q;
  assign sweep_partial = snap_part_q;
  assign fmt_err       = fmt_err_q;
  assign seq_err       = seq_err_q;
  assign overrun       = overrun_q;
  assign drop_cnt      = drop_cnt_q;
`ifdef SWEEP_STAMP_EN
  assign sweep_num     = sweep_num_q;
`endif

endmodule

// File: tb/tb_spike_event_decoder.sv
// Directed self-checking bench for spike_event_decoder.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_spike_event_decoder;

  logic         clk = 1'b0;
  logic         reset_bar = 1'b0;
  logic         spkid_valid = 1'b0;
  logic [15:0]  spkid = 16'd0;
  logic         spike = 1'b0;
  logic         ev_valid;
  logic         ev_ready = 1'b0;
  logic [6:0]   ev_id;
  logic         sweep_valid;
  logic         sweep_ready = 1'b0;
  logic [127:0] population;
  logic [7:0]   spike_count;
  logic         sweep_partial;
  logic         fmt_err;
  logic         seq_err;
  logic         overrun;
  logic [15:0]  drop_cnt;
`ifdef SWEEP_STAMP_EN
  logic [15:0]  sweep_num;
`endif

  int checks = 0;
  int passes = 0;

  spike_event_decoder #(
    .FIFO_DEPTH (16),
    .FIFO_AW    (4),
    .DROP_CNT_W (16)
  ) dut (
    .clk           (clk),
    .reset_bar     (reset_bar),
    .spkid_valid   (spkid_valid),
    .spkid         (spkid),
    .spike         (spike),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_id         (ev_id),
    .sweep_valid   (sweep_valid),
    .sweep_ready   (sweep_ready),
    .population    (population),
    .spike_count   (spike_count),
    .sweep_partial (sweep_partial),
    .fmt_err       (fmt_err),
    .seq_err       (seq_err),
    .overrun       (overrun),
    .drop_cnt      (drop_cnt)
`ifdef SWEEP_STAMP_EN
    ,
    .sweep_num     (sweep_num)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive_slot(input int idx, input logic f);
    @(negedge clk);
    spkid_valid = 1'b1;
    spkid       = {1'b0, 7'(idx), f, 7'd0};
    spike       = f;
  endtask

  task automatic go_idle(input int n);
    @(negedge clk);
    spkid_valid = 1'b0;
    spkid       = 16'd0;
    spike       = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_range(input int lo, input int hi, input logic [127:0] fire);
    for (int i = lo; i <= hi; i++) drive_slot(i, fire[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_bar   = 1'b0;
    spkid_valid = 1'b0;
    spkid       = 16'd0;
    spike       = 1'b0;
    ev_ready    = 1'b0;
    sweep_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_bar = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [170:0] all_out;
    do_reset();
    all_out = {ev_valid, sweep_valid, population, spike_count, sweep_partial,
               fmt_err, seq_err, overrun, drop_cnt};
    checks++;
    if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out);
    else passes++;
  endtask

  task automatic test_full_sweep();
    logic [127:0] fire;
    logic [127:0] want;
    logic [6:0]   exp_ids [3];
    do_reset();
    fire = '0;
    fire[3] = 1'b1; fire[64] = 1'b1; fire[127] = 1'b1;
    want = fire;
    exp_ids[0] = 7'd3; exp_ids[1] = 7'd64; exp_ids[2] = 7'd127;
    for (int i = 0; i <= 127; i++) begin
      drive_slot(i, fire[i]);
      if (i == 5) begin
        checks++;
        if (ev_valid !== 1'b0) $display("FAIL ev_latency_early: got %b want 0", ev_valid);
        else passes++;
      end
      if (i == 6) begin
        checks++;
        if (ev_valid !== 1'b1 || ev_id !== 7'd3)
          $display("FAIL ev_latency_2cyc: got v=%b id=%0d want v=1 id=3", ev_valid, ev_id);
        else passes++;
      end
    end
    go_idle(4);
    checks++;
    if (sweep_valid !== 1'b1 || population !== want || spike_count !== 8'd3 ||
        sweep_partial !== 1'b0)
      $display("FAIL sweep_basic: got v=%b pop=%h cnt=%0d part=%b want v=1 pop=%h cnt=3 part=0",
               sweep_valid, population, spike_count, sweep_partial, want);
    else passes++;
    checks++;
    if (seq_err !== 1'b0 || fmt_err !== 1'b0 || overrun !== 1'b0)
      $display("FAIL sweep_basic_flags: got seq=%b fmt=%b ovr=%b want 0 0 0",
               seq_err, fmt_err, overrun);
    else passes++;
`ifdef SWEEP_STAMP_EN
    checks++;
    if (sweep_num !== 16'd1) $display("FAIL sweep_num_first: got %0d want 1", sweep_num);
    else passes++;
`endif
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ev_valid !== 1'b1 || ev_id !== exp_ids[k])
        $display("FAIL ev_order_%0d: got v=%b id=%0d want v=1 id=%0d",
                 k, ev_valid, ev_id, exp_ids[k]);
      else passes++;
      ev_ready = 1'b1;
    end
    @(negedge clk);
    ev_ready = 1'b0;
    checks++;
    if (ev_valid !== 1'b0) $display("FAIL ev_drain: got %b want 0", ev_valid);
    else passes++;
  endtask

  task automatic test_fifo_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) drive_slot(i, 1'b1);
    go_idle(4);
    checks++;
    if (drop_cnt !== 16'd4) $display("FAIL drop_cnt: got %0d want 4", drop_cnt);
    else passes++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (ev_valid !== 1'b1 || ev_id !== 7'(k))
        $display("FAIL fifo_pop_%0d: got v=%b id=%0d want v=1 id=%0d", k, ev_valid, ev_id, k);
      else passes++;
      ev_ready = 1'b1;
    end
    @(negedge clk);
    ev_ready = 1'b0;
    checks++;
    if (ev_valid !== 1'b0) $display("FAIL fifo_empty_after16: got %b want 0", ev_valid);
    else passes++;
  endtask

  task automatic test_seq_error();
    logic [127:0] fire;
    logic [127:0] want;
    do_reset();
    fire = '0;
    fire[5] = 1'b1; fire[12] = 1'b1; fire[100] = 1'b1;
    want = '0;
    want[12] = 1'b1; want[100] = 1'b1;
    ev_ready = 1'b1;
    send_range(0, 10, fire);
    send_range(12, 127, fire);
    go_idle(4);
    checks++;
    if (seq_err !== 1'b1) $display("FAIL seq_err_set: got %b want 1", seq_err);
    else passes++;
    checks++;
    if (sweep_valid !== 1'b1 || sweep_partial !== 1'b1 || population !== want ||
        spike_count !== 8'd2)
      $display("FAIL seq_partial_sweep: got v=%b part=%b pop=%h cnt=%0d want v=1 part=1 pop=%h cnt=2",
               sweep_valid, sweep_partial, population, spike_count, want);
    else passes++;
    ev_ready = 1'b0;
  endtask

  task automatic test_fmt_error();
    do_reset();
    @(negedge clk);
    spkid_valid = 1'b1; spkid = 16'h8000; spike = 1'b0;
    @(negedge clk);
    spkid = 16'h0000; spike = 1'b1;        // spike disagrees with spkid[7]
    @(negedge clk);
    spkid = 16'h0081; spike = 1'b1;        // fired but low bits nonzero
    go_idle(4);
    checks++;
    if (fmt_err !== 1'b1) $display("FAIL fmt_err_set: got %b want 1", fmt_err);
    else passes++;
    checks++;
    if (ev_valid !== 1'b0) $display("FAIL fmt_no_fifo_write: got %b want 0", ev_valid);
    else passes++;
    drive_slot(0, 1'b1);
    go_idle(4);
    checks++;
    if (seq_err !== 1'b0 || ev_valid !== 1'b1 || ev_id !== 7'd0)
      $display("FAIL fmt_expected_unchanged: got seq=%b v=%b id=%0d want seq=0 v=1 id=0",
               seq_err, ev_valid, ev_id);
    else passes++;
  endtask

  task automatic test_overrun();
    logic [127:0] fire_a;
    logic [127:0] fire_b;
    do_reset();
    ev_ready = 1'b1;
    fire_a = '0; fire_a[1] = 1'b1;
    fire_b = '0; fire_b[2] = 1'b1; fire_b[5] = 1'b1;
    send_range(0, 127, fire_a);
    go_idle(4);
    checks++;
    if (overrun !== 1'b0 || population !== fire_a)
      $display("FAIL overrun_first_sweep: got ovr=%b pop=%h want ovr=0 pop=%h",
               overrun, population, fire_a);
    else passes++;
    send_range(0, 127, fire_b);
    go_idle(4);
    checks++;
    if (overrun !== 1'b1 || sweep_valid !== 1'b1 || population !== fire_b ||
        spike_count !== 8'd2)
      $display("FAIL overrun_second_sweep: got ovr=%b v=%b pop=%h cnt=%0d want ovr=1 v=1 pop=%h cnt=2",
               overrun, sweep_valid, population, spike_count, fire_b);
    else passes++;
    sweep_ready = 1'b1;
    @(negedge clk);
    sweep_ready = 1'b0;
    checks++;
    if (sweep_valid !== 1'b0) $display("FAIL sweep_ack: got %b want 0", sweep_valid);
    else passes++;
    ev_ready = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    logic [127:0] fire;
    logic [127:0] fire_new;
    logic [170:0] all_out;
    do_reset();
    fire = '0; fire[10] = 1'b1;
    fire_new = '0; fire_new[50] = 1'b1;
    send_range(0, 60, fire);
    @(negedge clk);
    spkid_valid = 1'b0;
    reset_bar   = 1'b0;
    #1;
    all_out = {ev_valid, sweep_valid, population, spike_count, sweep_partial,
               fmt_err, seq_err, overrun, drop_cnt};
    checks++;
    if (all_out !== '0) $display("FAIL reset_mid_outputs: got %h want 0", all_out);
    else passes++;
    repeat (2) @(negedge clk);
    reset_bar = 1'b1;
    ev_ready  = 1'b1;
    send_range(0, 127, fire_new);
    go_idle(4);
    checks++;
    if (sweep_valid !== 1'b1 || population !== fire_new || spike_count !== 8'd1 ||
        sweep_partial !== 1'b0 || seq_err !== 1'b0)
      $display("FAIL reset_mid_new_sweep: got v=%b pop=%h cnt=%0d part=%b seq=%b want v=1 pop=%h cnt=1 part=0 seq=0",
               sweep_valid, population, spike_count, sweep_partial, seq_err, fire_new);
    else passes++;
`ifdef SWEEP_STAMP_EN
    checks++;
    if (sweep_num !== 16'd1) $display("FAIL sweep_num_restart: got %0d want 1", sweep_num);
    else passes++;
`endif
    ev_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_fifo_overflow();
    test_seq_error();
    test_fmt_error();
    test_overrun();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spike_event_decoder.md
Name: spike_event_decoder

Overview:
Receiving end of the spike/spkid stream produced by the time-multiplexed 128-neuron Izhikevich core. It decodes each neuron slot word and performs three jobs:
- Queues the IDs of fired neurons into an event FIFO with a valid/ready output.
- Assembles a 128-bit population snapshot plus spike count per full sweep (index 0..127), with a valid/ready handshake.
- Flags malformed or out-of-sequence slots.

It sits between the neuron core and host readout / downstream synapse logic.

Parameters:
FIFO_DEPTH, 16, event FIFO entries; power of two, 2..256
FIFO_AW, 4, log2(FIFO_DEPTH)
DROP_CNT_W, 16, width of saturating dropped-event counter

Ports:
clk  in  1  system clock, rising edge
reset_bar  in  1  asynchronous active-low reset
spkid_valid  in  1  one-cycle strobe per neuron slot; spkid/spike are sampled only when it is high
spkid  in  16  slot word {1'b0, idx[6:0], fired, 7'b0}
spike  in  1  fired flag from the core; cross-checked against spkid[7]
ev_valid  out  1  FIFO head valid
ev_ready  in  1  consumer accepts head
ev_id  out  7  neuron index at FIFO head
sweep_valid  out  1  snapshot available
sweep_ready  in  1  consumer accepts snapshot
population  out  128  bit i = neuron i fired in the last completed sweep
spike_count  out  8  popcount of population, 0..128
sweep_partial  out  1  snapshot sweep contained a sequence error
fmt_err  out  1  sticky: malformed slot seen
seq_err  out  1  sticky: index discontinuity seen
overrun  out  1  sticky: sweep completed while the previous one was unacknowledged
drop_cnt  out  DROP_CNT_W  saturating count of fired events lost to a full FIFO

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO empty; expected index 0; working population and count cleared.
- Sampling, stage 1: on a rising edge with spkid_valid=1, register idx=spkid[14:8], f=spkid[7]. spkid_valid=0 means no action.
- Format check: spkid[15]=1, spkid[6:0]!=0, or spike!=spkid[7] → fmt_err<=1. The slot is discarded and the expected index is not advanced.
- Sequence check, stage 2:
  - idx==expected → normal.
  - idx!=expected → seq_err<=1; set the working partial flag; clear the working population and count; continue from idx.
  - After every good slot, expected<=(idx+1) mod 128.
- Working population: bit idx <= f; count += f.
- Sweep completion: a good slot with idx==127 loads the snapshot on the next edge.
  - Snapshot = population, spike_count and sweep_partial, taken from the working set including slot 127.
  - On load: sweep_valid<=1, working set cleared, partial flag cleared.
  - Snapshot outputs hold while sweep_valid && !sweep_ready.
  - The handshake completes on an edge with sweep_valid && sweep_ready; sweep_valid then drops unless a new snapshot loads on that same edge, in which case it stays high.
  - Completion while sweep_valid=1 and sweep_ready=0 → the snapshot is overwritten and overrun<=1.
- Event FIFO:
  - A good slot with f=1 writes idx in stage 2.
  - ev_valid rises on the edge after the write, i.e. 2 cycles after the sampling edge.
  - Pop on ev_valid && ev_ready.
  - Simultaneous push and pop on a full FIFO is legal: both occur and nothing is dropped.
  - Push on a full FIFO without a pop → the event is dropped and drop_cnt increments, saturating at all-ones.
  - Pointers wrap modulo FIFO_DEPTH; ev_id is valid only while ev_valid=1.
- Throughput: one slot per cycle sustained; upstream delivers at most one slot per 2 cycles.
- Sticky flags clear only on reset.
- Reset mid-sweep discards the working set, the snapshot and the FIFO contents.

Optional Feature:
SWEEP_STAMP_EN
- Defined: adds output sweep_num[15:0] plus an internal 16-bit counter that increments, wrapping, on every snapshot load. sweep_num is latched with the snapshot and reset to 0.
- Undefined: no port, no counter; everything else is identical.

Test Plan:
- Reset, then 128 in-order slots with neurons 3, 64 and 127 fired → sweep_valid=1; population bits {3,64,127} set; spike_count=3; sweep_partial=0. ev_id sequence is 3, 64, 127, first ev_valid 2 cycles after slot 3.
- ev_ready=0 with 20 fired slots, FIFO_DEPTH=16 → 16 queued, drop_cnt=4. Then ev_ready=1 → IDs pop in order, ev_valid drops after 16.
- Slot idx 10 followed by idx 12 → seq_err=1. The sweep ending at 127 has sweep_partial=1, and population contains only slots from 12 onward.
- spkid=16'h8000 with spkid_valid=1, and separately spike=1 with spkid[7]=0 → fmt_err=1; no FIFO write; expected index unchanged.
- Two full sweeps with sweep_ready=0 → overrun=1 and the snapshot equals the second sweep. A sweep_ready pulse then clears sweep_valid.
- Full sweep, assert reset_bar=0 at slot 60, release, then a new sweep → all outputs 0 during reset; the next snapshot reflects only the new sweep. With SWEEP_STAMP_EN, sweep_num restarts at 1.
